// File: rtl/rv32i_types.sv
// Shared types for the CPU memory-side blocks: arbiter FSM states, port ids
// and the latched request record.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_IMEM,
    PORT_DMEM
  } port_id_t;

  typedef struct packed {
    port_id_t         port;
    logic [XLEN-1:0]  addr;
    logic [3:0]       rmask;
    logic [3:0]       wmask;
    logic [XLEN-1:0]  wdata;
  } mem_req_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU imem/dmem ports and the backing-memory port seen by the
// arbiter; slave is the arbiter's view, master is the surrounding system's.
interface mem_port_arbiter_if;

  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU imem reads and dmem reads/writes onto one single-ported
// backing memory, one transaction at a time, with registered response pulses.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter logic ALT_GRANT = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        last_dmem_q, last_dmem_d;

  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        imem_resp_q, imem_resp_d;
  logic        dmem_resp_q, dmem_resp_d;
  logic [31:0] imem_rdata_q, imem_rdata_d;
  logic [31:0] dmem_rdata_q, dmem_rdata_d;

  logic        imem_req;
  logic        dmem_req;
  logic        grant_dmem;
  logic        grant_write;
  logic        imem_fresh;

  always_comb begin
    imem_req    = |bus.imem_rmask;
    dmem_req    = (|bus.dmem_rmask) || (|bus.dmem_wmask);
    grant_dmem  = dmem_req && (!imem_req || !ALT_GRANT || !last_dmem_q);
    grant_write = grant_dmem && (|bus.dmem_wmask);
    imem_fresh  = imem_req && (bus.imem_addr == req_q.addr);
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_dmem_d  = last_dmem_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    imem_resp_d  = 1'b0;
    dmem_resp_d  = 1'b0;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          if (grant_dmem) begin
            req_d.port  = PORT_DMEM;
            req_d.addr  = bus.dmem_addr;
            req_d.rmask = bus.dmem_rmask;
            req_d.wmask = bus.dmem_wmask;
            req_d.wdata = bus.dmem_wdata;
          end else begin
            req_d.port  = PORT_IMEM;
            req_d.addr  = bus.imem_addr;
            req_d.rmask = bus.imem_rmask;
            req_d.wmask = 4'h0;
            req_d.wdata = 32'h0;
          end
          last_dmem_d = grant_dmem;
          mem_addr_d  = word_align(grant_dmem ? bus.dmem_addr : bus.imem_addr);
          mem_write_d = grant_write;
          mem_read_d  = !grant_write;
          mem_wmask_d = grant_write ? bus.dmem_wmask : 4'h0;
          mem_wdata_d = grant_write ? bus.dmem_wdata : 32'h0;
          state_d     = WAIT;
        end
      end

      // The stale-imem check is taken on the mem_resp edge so that the
      // response pulse visible during DONE still comes straight from a flop.
      WAIT: begin
        if (bus.mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
          if (req_q.port == PORT_DMEM) begin
            dmem_resp_d  = 1'b1;
            dmem_rdata_d = bus.mem_rdata;
          end else begin
            imem_resp_d  = imem_fresh;
            imem_rdata_d = bus.mem_rdata;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      last_dmem_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wmask_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
      imem_rdata_q <= 32'h0;
      dmem_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_dmem_q  <= last_dmem_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_resp_q  <= imem_resp_d;
      dmem_resp_q  <= dmem_resp_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.imem_resp  = imem_resp_q;
  assign bus.imem_rdata = imem_rdata_q;
  assign bus.dmem_resp  = dmem_resp_q;
  assign bus.dmem_rdata = dmem_rdata_q;

  // A dmem access with both masks set is a CPU bug; the RTL treats it as a write.
  illegal_dmem_rw: assert property (@(posedge clk) disable iff (rst)
    !((|bus.dmem_rmask) && (|bus.dmem_wmask)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a modelled backing memory, a response scoreboard,
// a vector table and hand-written arbitration / stale / reset sequences.
module tb_mem_port_arbiter;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter_if bus_fix();

  mem_port_arbiter #(.ALT_GRANT(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mem_port_arbiter #(.ALT_GRANT(1'b0)) dut_fix (
    .clk(clk),
    .rst(rst),
    .bus(bus_fix)
  );

  typedef struct {
    port_id_t    port;
    logic [31:0] data;
    logic        check_data;
  } exp_resp_t;

  typedef struct {
    logic        is_dmem;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_addr;
    logic        exp_write;
    logic [31:0] exp_rdata;
  } vec_t;

  int num_vectors = 0;
  int num_miscompares = 0;
  int cycle = 0;

  exp_resp_t   sb[$];
  logic [31:0] bmem [bit [31:0]];
  int          resp_count = 0;
  int          last_resp_cycle = 0;

  int          mem_delay = 1;
  logic        m_busy = 1'b0;
  int          m_count = 0;
  int          issue_count = 0;
  logic [31:0] last_issue_addr = 32'h0;
  logic        last_issue_write = 1'b0;
  logic [3:0]  last_issue_wmask = 4'h0;
  logic [31:0] last_issue_wdata = 32'h0;
  logic        abort_pending = 1'b0;

  logic        fix_prev_strobe = 1'b0;
  logic        fix_prev_resp = 1'b0;
  port_id_t    fix_order[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    num_vectors++;
    if (actual !== required) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)",
               name, actual, required, cycle);
    end
  endtask

  function automatic logic [31:0] read_word(input logic [31:0] a);
    bit [31:0] key;
    key = {a[31:2], 2'b00};
    if (bmem.exists(key)) return bmem[key];
    return {key[15:0], ~key[15:0]};
  endfunction

  task automatic resp_observed(input port_id_t p, input logic [31:0] d);
    exp_resp_t e;
    resp_count++;
    last_resp_cycle = cycle;
    if (sb.size() == 0) begin
      num_vectors++;
      num_miscompares++;
      $display("[TB] FAIL unexpected resp: got port %0d data 0x%08h, required none (cycle %0d)",
               p, d, cycle);
    end else begin
      e = sb.pop_front();
      checkOutput("resp port", 32'(p), 32'(e.port));
      if (e.check_data) checkOutput("resp rdata", d, e.data);
    end
  endtask

  // One clock: sample outputs just after the edge, then drive inputs for the next edge.
  task automatic tick();
    logic [31:0] old;
    @(posedge clk);
    #1;
    cycle++;
    if (bus.imem_resp) resp_observed(PORT_IMEM, bus.imem_rdata);
    if (bus.dmem_resp) resp_observed(PORT_DMEM, bus.dmem_rdata);
    if (bus.mem_read && bus.mem_write)
      checkOutput("read/write exclusive", {31'b0, bus.mem_read & bus.mem_write}, 32'h0);

    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'hBAD0_0000;
    if (!m_busy && (bus.mem_read || bus.mem_write)) begin
      m_busy = 1'b1;
      m_count = 0;
      issue_count++;
      last_issue_addr  = bus.mem_addr;
      last_issue_write = bus.mem_write;
      last_issue_wmask = bus.mem_wmask;
      last_issue_wdata = bus.mem_wdata;
    end else if (m_busy && !(bus.mem_read || bus.mem_write) && !abort_pending) begin
      checkOutput("strobe held until mem_resp", {31'b0, bus.mem_read | bus.mem_write}, 32'h1);
    end
    if (m_busy) begin
      if (m_count == mem_delay) begin
        if (last_issue_write) begin
          old = read_word(last_issue_addr);
          for (int b = 0; b < 4; b++)
            if (last_issue_wmask[b]) old[8*b +: 8] = last_issue_wdata[8*b +: 8];
          bmem[{last_issue_addr[31:2], 2'b00}] = old;
          bus.mem_rdata = 32'hDEAD_BEEF;
        end else begin
          bus.mem_rdata = read_word(last_issue_addr);
        end
        bus.mem_resp  = 1'b1;
        m_busy        = 1'b0;
        abort_pending = 1'b0;
      end else begin
        m_count++;
      end
    end

    if (bus_fix.imem_resp) fix_order.push_back(PORT_IMEM);
    if (bus_fix.dmem_resp) fix_order.push_back(PORT_DMEM);
    bus_fix.mem_resp  = bus_fix.mem_read && fix_prev_strobe && !fix_prev_resp;
    bus_fix.mem_rdata = 32'(cycle);
    fix_prev_resp     = bus_fix.mem_resp;
    fix_prev_strobe   = bus_fix.mem_read;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " mem_read"},   {31'b0, bus.mem_read},  32'h0);
    checkOutput({tag, " mem_write"},  {31'b0, bus.mem_write}, 32'h0);
    checkOutput({tag, " mem_addr"},   bus.mem_addr,           32'h0);
    checkOutput({tag, " mem_wmask"},  {28'b0, bus.mem_wmask}, 32'h0);
    checkOutput({tag, " mem_wdata"},  bus.mem_wdata,          32'h0);
    checkOutput({tag, " imem_resp"},  {31'b0, bus.imem_resp}, 32'h0);
    checkOutput({tag, " dmem_resp"},  {31'b0, bus.dmem_resp}, 32'h0);
    checkOutput({tag, " imem_rdata"}, bus.imem_rdata,         32'h0);
    checkOutput({tag, " dmem_rdata"}, bus.dmem_rdata,         32'h0);
  endtask

  task automatic drop_requests();
    bus.imem_rmask = 4'h0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
  endtask

  // Drives one vector from an idle arbiter and follows it through to IDLE again.
  task automatic applyStimulus(input int idx, input vec_t v);
    int start;
    int r0;
    int issues;
    string tag;
    tag = $sformatf("v%0d", idx);
    mem_delay = v.delay;
    if (v.is_dmem) begin
      bus.dmem_addr  = v.addr;
      bus.dmem_rmask = v.rmask;
      bus.dmem_wmask = v.wmask;
      bus.dmem_wdata = v.wdata;
    end else begin
      bus.imem_addr  = v.addr;
      bus.imem_rmask = v.rmask;
    end
    sb.push_back('{port: v.is_dmem ? PORT_DMEM : PORT_IMEM, data: v.exp_rdata,
                   check_data: !v.exp_write});
    start = cycle;
    r0 = resp_count;
    tick();
    checkOutput({tag, " mem_addr"},  bus.mem_addr, v.exp_addr);
    checkOutput({tag, " mem_write"}, {31'b0, bus.mem_write}, {31'b0, v.exp_write});
    checkOutput({tag, " mem_read"},  {31'b0, bus.mem_read},  {31'b0, !v.exp_write});
    if (v.exp_write) begin
      checkOutput({tag, " mem_wmask"}, {28'b0, bus.mem_wmask}, {28'b0, v.wmask});
      checkOutput({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
    end
    for (int i = 0; i < 40 && resp_count == r0; i++) tick();
    checkOutput({tag, " resp seen"}, 32'(resp_count - r0), 32'h1);
    checkOutput({tag, " resp latency"}, 32'(last_resp_cycle - start), 32'(v.delay + 2));
    checkOutput({tag, " strobe low in DONE"}, {31'b0, bus.mem_read | bus.mem_write}, 32'h0);
    issues = issue_count;
    tick();
    checkOutput({tag, " resp one cycle"}, {31'b0, bus.imem_resp | bus.dmem_resp}, 32'h0);
    checkOutput({tag, " no grant in DONE"}, {31'b0, bus.mem_read | bus.mem_write}, 32'h0);
    drop_requests();
    tick();
    checkOutput({tag, " no reissue"}, 32'(issue_count - issues), 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    port_id_t exp_fix[3];
    int dmem_seen;
    int fix_dmem_seen;
    int r0;
    int start;
    int issues0;

    bus.imem_addr = 32'h0;  bus.imem_rmask = 4'h0;
    bus.dmem_addr = 32'h0;  bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;  bus.dmem_wdata = 32'h0;
    bus.mem_rdata = 32'h0;  bus.mem_resp = 1'b0;
    bus_fix.imem_addr = 32'h0;  bus_fix.imem_rmask = 4'h0;
    bus_fix.dmem_addr = 32'h0;  bus_fix.dmem_rmask = 4'h0;
    bus_fix.dmem_wmask = 4'h0;  bus_fix.dmem_wdata = 32'h0;
    bus_fix.mem_rdata = 32'h0;  bus_fix.mem_resp = 1'b0;

    bmem[32'h6000_0004] = 32'h0000_0013;
    bmem[32'h6000_0100] = 32'h1122_3344;
    bmem[32'h6000_0200] = 32'hCAFE_BABE;

    //       dmem  addr          rmask wmask  wdata         dly exp_addr      wr  exp_rdata
    vecs[0] = '{1'b0, 32'h6000_0004, 4'hF, 4'h0,   32'h0,         1, 32'h6000_0004, 1'b0, 32'h0000_0013};
    vecs[1] = '{1'b1, 32'h6000_0102, 4'h0, 4'b1100, 32'hABCD_0000, 1, 32'h6000_0100, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 32'h6000_0103, 4'h1, 4'h0,   32'h0,         3, 32'h6000_0100, 1'b0, 32'hABCD_3344};
    vecs[3] = '{1'b0, 32'h6000_0008, 4'hF, 4'h0,   32'h0,         2, 32'h6000_0008, 1'b0, 32'h0008_FFF7};
    vecs[4] = '{1'b1, 32'h6000_0201, 4'h0, 4'b0001, 32'h0000_00EE, 1, 32'h6000_0200, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h6000_0200, 4'hF, 4'h0,   32'h0,        10, 32'h6000_0200, 1'b0, 32'hCAFE_BAEE};
    vecs[6] = '{1'b1, 32'h6000_020E, 4'hC, 4'h0,   32'h0,         2, 32'h6000_020C, 1'b0, 32'h020C_FDF3};

    $display("[TB] reset");
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    $display("[TB] simultaneous requests from reset");
    mem_delay = 1;
    bus.imem_addr = 32'h6000_0004;  bus.imem_rmask = 4'hF;
    bus.dmem_addr = 32'h6000_0100;  bus.dmem_rmask = 4'hF;
    sb.push_back('{port: PORT_DMEM, data: 32'h1122_3344, check_data: 1'b1});
    sb.push_back('{port: PORT_IMEM, data: 32'h0000_0013, check_data: 1'b1});
    bus_fix.imem_addr = 32'h6000_0040;  bus_fix.imem_rmask = 4'hF;
    bus_fix.dmem_addr = 32'h6000_0140;  bus_fix.dmem_rmask = 4'hF;
    dmem_seen = 0;
    fix_dmem_seen = 0;
    for (int i = 0; i < 80 && !(sb.size() == 0 && fix_order.size() >= 3); i++) begin
      tick();
      if (bus.dmem_resp) begin
        dmem_seen++;
        if (dmem_seen == 1) begin
          bus.dmem_addr = 32'h6000_0200;
          sb.push_back('{port: PORT_DMEM, data: 32'hCAFE_BABE, check_data: 1'b1});
        end else begin
          bus.dmem_rmask = 4'h0;
        end
      end
      if (bus.imem_resp) bus.imem_rmask = 4'h0;
      if (bus_fix.dmem_resp) begin
        fix_dmem_seen++;
        if (fix_dmem_seen == 1) bus_fix.dmem_addr = 32'h6000_0180;
        else bus_fix.dmem_rmask = 4'h0;
      end
      if (bus_fix.imem_resp) bus_fix.imem_rmask = 4'h0;
    end
    checkOutput("alt1 all served", 32'(sb.size()), 32'h0);
    checkOutput("alt0 resp count", 32'(fix_order.size()), 32'h3);
    exp_fix = '{PORT_DMEM, PORT_DMEM, PORT_IMEM};
    for (int i = 0; i < 3 && i < fix_order.size(); i++)
      checkOutput($sformatf("alt0 order[%0d]", i), 32'(fix_order[i]), 32'(exp_fix[i]));
    drop_requests();
    bus_fix.imem_rmask = 4'h0;
    bus_fix.dmem_rmask = 4'h0;
    tick();
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    $display("[TB] stale imem fetch");
    mem_delay = 2;
    bus.imem_addr  = 32'h6000_0010;
    bus.imem_rmask = 4'hF;
    start = cycle;
    r0 = resp_count;
    issues0 = issue_count;
    tick();
    bus.imem_addr = 32'h6000_0080;
    sb.push_back('{port: PORT_IMEM, data: 32'h0080_FF7F, check_data: 1'b1});
    for (int i = 0; i < 40 && resp_count == r0; i++) tick();
    checkOutput("stale resp count", 32'(resp_count - r0), 32'h1);
    checkOutput("stale redirect latency", 32'(last_resp_cycle - start), 32'd9);
    checkOutput("stale reissue addr", last_issue_addr, 32'h6000_0080);
    checkOutput("stale issue count", 32'(issue_count - issues0), 32'h2);
    drop_requests();
    tick();
    tick();

    $display("[TB] reset during WAIT");
    mem_delay = 1;
    bus.dmem_addr  = 32'h6000_0300;
    bus.dmem_rmask = 4'hF;
    r0 = resp_count;
    tick();
    checkOutput("abort mem_read", {31'b0, bus.mem_read}, 32'h1);
    rst = 1'b1;
    abort_pending = 1'b1;
    drop_requests();
    tick();
    check_all_zero("abort");
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("abort no resp", 32'(resp_count - r0), 32'h0);
    checkOutput("abort idle strobe", {31'b0, bus.mem_read | bus.mem_write}, 32'h0);
    applyStimulus(7, vecs[0]);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

  initial begin
    #100000;
    num_miscompares++;
    $display("[TB] FAIL watchdog: got timeout, required completion (cycle %0d)", cycle);
    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
